// File: rtl/multicycle_mainfsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_pkg                                                    |
// | Purpose  : State type and datapath select encodings shared by the    |
// |            multicycle main decoder and its surroundings.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mc_pkg;

  // Main controller states; explicit 4-bit width leaves six spare codes.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } statetype_t;

  // ALU B operand select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction class in Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_mainfsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multicycle_mainfsm_if                                     |
// | Purpose  : Instruction fields, memory ready and datapath control     |
// |            lines between the main decoder and the datapath.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface multicycle_mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Illegal;

  // Controller side: consumes instruction fields, drives control lines.
  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, Illegal
  );

  // Datapath side: supplies instruction fields, consumes control lines.
  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_mainfsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : multicycle_mainfsm                                        |
// | Purpose  : Main decoder FSM of a multicycle ARM-subset core; steps   |
// |            the shared memory, ALU and register file through fetch,   |
// |            decode, execute and writeback with memory wait states.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module multicycle_mainfsm
  import mc_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_mainfsm_if.master  bus
);

  statetype_t r_state;
  statetype_t w_next;

  // Funct[2:1] carry no meaning for the main decoder.
  logic w_unused_funct;
  assign w_unused_funct = ^bus.Funct[2:1];

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state selection; spare encodings fall back to FETCH.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          OP_DP:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  w_next = MEMADR;
          OP_BR:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = bus.MemReady ? MEMWB : MEMREAD;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = bus.MemReady ? FETCH : MEMWRITE;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // Control decode; defaults hold the PC+4 path so idle states are harmless.
  // Qualified strobes are masked by reset so nothing is written while held.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b1;
    bus.ALUSrcB   = SRCB_FOUR;
    bus.ResultSrc = RES_ALU;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        bus.IRWrite = bus.MemReady & ~reset;
        bus.NextPC  = bus.MemReady & ~reset;
      end
      DECODE: begin
        bus.Illegal = (bus.Op == OP_UND);
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegW      = 1'b1;
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = ~reset;
      end
      EXECUTER: begin
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = SRCB_RD2;
        bus.ALUOp   = 1'b1;
      end
      EXECUTEI: begin
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = 1'b1;
      end
      ALUWB: begin
        // CMP/TST only set flags.
        bus.ResultSrc = RES_ALUOUT;
        bus.RegW      = (bus.Funct[4:3] != 2'b10);
      end
      BRANCH: begin
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        bus.Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mainfsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_multicycle_mainfsm                                     |
// | Purpose  : Self-checking bench for the multicycle main decoder.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_multicycle_mainfsm;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_mainfsm_if bus ();

  multicycle_mainfsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
    logic       aluop;
    logic       ill;
  } ctl_t;

  // Expected per-cycle controls and the MemReady to present in that cycle.
  ctl_t exp_q[$];
  bit   rdy_q[$];

  function automatic ctl_t idle_ctl();
    ctl_t c = '0;
    c.srca = 1'b1;
    c.srcb = 2'b10;
    c.res  = 2'b10;
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.irw = bus.IRWrite;  c.adr = bus.AdrSrc;   c.srca = bus.ALUSrcA;
    c.srcb = bus.ALUSrcB; c.res = bus.ResultSrc; c.npc = bus.NextPC;
    c.regw = bus.RegW;    c.memw = bus.MemW;    c.br = bus.Branch;
    c.aluop = bus.ALUOp;  c.ill = bus.Illegal;
    return c;
  endfunction

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Reference: instruction timeline as a list of phases, each phase one cycle.
  task automatic build_model(input logic [1:0] op, input logic [5:0] funct,
                             input int fw, input int mw);
    ctl_t c;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i < fw; i++) begin
      exp_q.push_back(idle_ctl()); rdy_q.push_back(1'b0);
    end
    c = idle_ctl(); c.irw = 1'b1; c.npc = 1'b1;
    exp_q.push_back(c); rdy_q.push_back(1'b1);
    c = idle_ctl(); c.ill = (op == 2'b11);
    exp_q.push_back(c); rdy_q.push_back(rnd_bit());
    case (op)
      2'b00: begin
        c = idle_ctl(); c.srca = 1'b0; c.srcb = funct[5] ? 2'b01 : 2'b00; c.aluop = 1'b1;
        exp_q.push_back(c); rdy_q.push_back(rnd_bit());
        c = idle_ctl(); c.res = 2'b00; c.regw = (funct[4:3] != 2'b10);
        exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end
      2'b01: begin
        c = idle_ctl(); c.srca = 1'b0; c.srcb = 2'b01;
        exp_q.push_back(c); rdy_q.push_back(rnd_bit());
        c = idle_ctl(); c.adr = 1'b1; c.memw = ~funct[0];
        for (int i = 0; i < mw; i++) begin
          exp_q.push_back(c); rdy_q.push_back(1'b0);
        end
        exp_q.push_back(c); rdy_q.push_back(1'b1);
        if (funct[0]) begin
          c = idle_ctl(); c.res = 2'b01; c.regw = 1'b1;
          exp_q.push_back(c); rdy_q.push_back(rnd_bit());
        end
      end
      2'b10: begin
        c = idle_ctl(); c.srca = 1'b0; c.srcb = 2'b01; c.br = 1'b1;
        exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end
      default: ;
    endcase
  endtask

  // Plays the model against the DUT; limit > 0 stops after that many cycles.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] funct, input int fw, input int mw,
                           input int limit);
    ctl_t got;
    build_model(op, funct, fw, mw);
    bus.Op    = op;
    bus.Funct = funct;
    for (int i = 0; i < exp_q.size() && (limit == 0 || i < limit); i++) begin
      bus.MemReady = rdy_q[i];
      @(negedge clk);
      got = observe();
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i, got, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name);
    ctl_t got;
    got = observe();
    n_checks++;
    if (got !== idle_ctl()) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, idle_ctl());
    end
  endtask

  task automatic test_reset();
    bus.MemReady = 1'b1; bus.Op = 2'b00; bus.Funct = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset_held_ready");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.MemReady = 1'b0;
    @(negedge clk);
    check_idle("after_reset_no_ready");
    @(posedge clk); #1;
    // ADD register up to EXECUTER, then reset mid-state.
    run_instr("pre_exec_r", 2'b00, 6'b001000, 0, 0, 2);
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_reset_exec");
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("resume_after_exec_reset", 2'b00, 6'b001000, 2, 0, 0);
  endtask

  task automatic test_add_imm();
    run_instr("add_imm", 2'b00, 6'b101000, 0, 0, 0);
  endtask

  task automatic test_cmp_reg();
    run_instr("cmp_reg", 2'b00, 6'b010101, 0, 0, 0);
  endtask

  task automatic test_ldr_wait();
    run_instr("ldr_wait2", 2'b01, 6'b011001, 0, 2, 0);
  endtask

  task automatic test_str_wait();
    ctl_t got;
    run_instr("str_wait3", 2'b01, 6'b011000, 0, 3, 0);
    // Second STR: reset pulse during its second wait cycle.
    run_instr("str_pre_reset", 2'b01, 6'b011000, 0, 3, 4);
    bus.MemReady = 1'b0;
    #2;
    got = observe();
    n_checks++;
    if (got.memw !== 1'b1) begin
      n_fail++;
      $display("FAIL str_wait2_memw: got %b expected 1", got.memw);
    end
    reset = 1'b1;
    #1;
    check_idle("str_async_reset");
    bus.MemReady = 1'b1;
    @(posedge clk); #1;
    check_idle("str_reset_held");
    reset = 1'b0;
    run_instr("branch_after_str_reset", 2'b10, 6'b100000, 1, 0, 0);
  endtask

  task automatic test_branch_illegal();
    run_instr("branch", 2'b10, 6'b010110, 0, 0, 0);
    run_instr("illegal", 2'b11, 6'b101101, 0, 0, 0);
    run_instr("after_illegal", 2'b00, 6'b001001, 1, 0, 0);
  endtask

  task automatic test_back_to_back_random();
    logic [1:0] op;
    logic [5:0] funct;
    for (int k = 0; k < 40; k++) begin
      op    = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      run_instr($sformatf("rand%0d", k), op, funct,
                $urandom_range(0, 2), $urandom_range(0, 3), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_add_imm();
    test_cmp_reg();
    test_ldr_wait();
    test_str_wait();
    test_branch_illegal();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
